snn_tdm_layer: RTL and testbench
================================

SNN_TDM_LAYER -- requirements
Module: snn_tdm_layer

Interface
REQ-001 Parameter INPUTS, default 16: synapses per neuron; INPUTS*NEURONS SHALL be a multiple of 8.
REQ-002 Parameter NEURONS, default 8: neurons, time-multiplexed over one shared accumulator.
REQ-003 Parameter POT_BITS, default 8: signed membrane-potential width.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  zeroes all potentials; acted on in IDLE only.
REQ-007 threshold  input  POT_BITS  unsigned firing threshold, sampled at timestep start.
REQ-008 shift  input  3  leak shift, sampled at timestep start; 0 means no leak.
REQ-009 wgt_valid / wgt_ready / wgt_data  in / out / in  1/1/8  weight-byte stream.
REQ-010 in_valid / in_ready / in_spikes  in / out / in  1/1/INPUTS  timestep start with input spikes.
REQ-011 out_valid / out_ready / out_spikes  out / in / out  1/1/NEURONS  timestep result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, ACC, DONE; IDLE->ACC on in handshake; ACC->DONE after NEURONS cycles; DONE->IDLE on out_valid&&out_ready.
REQ-014 in_ready = IDLE && !clr; wgt_ready = IDLE && !in_valid && !clr.
REQ-015 Weight handshake: weights <= {wgt_data, weights[W-1:8]}, W = INPUTS*NEURONS; first byte of a W/8-byte upload ends at bits [7:0].
REQ-016 Neuron k uses weights[k*INPUTS +: INPUTS]; weight bit 1 = +1, 0 = -1.
REQ-017 ACC cycle k (k = 0..NEURONS-1) updates neuron k only; in_spikes, threshold and shift are registered at the in handshake.
REQ-018 sum = popcount(in & w) - popcount(in & ~w), signed, width $clog2(INPUTS)+2.
REQ-019 u_next = sat(u - (shift ? u>>>shift : 0) + sum), saturated to signed POT_BITS range.
REQ-020 If u_next >= threshold (signed compare, threshold zero-extended), spike bit k = 1 and u <= u_next - threshold; else u <= u_next and bit k = 0.
REQ-021 Latency: in handshake at cycle t -> out_valid high from cycle t+NEURONS+1; out_spikes stable while out_valid.
REQ-022 out_valid held until out_ready; no new timestep or weight byte accepted meanwhile.
REQ-023 clr high in IDLE zeroes all potentials in one cycle and blocks both handshakes that cycle.
REQ-024 clr outside IDLE is ignored.

Reset
REQ-025 Reset: state IDLE, all potentials 0, all weights 1 (+1), out_spikes 0, out_valid 0, busy 0, registered config 0.
REQ-026 Reset during ACC or DONE aborts the timestep; no partial result is presented.

Configuration
REQ-027 Macro SNN_REFRACTORY_EN defined: a neuron that spiked in timestep n ignores sum in timestep n+1 (leak still applies, spike bit forced 0); one refractory flag per neuron, cleared by reset and clr.
REQ-028 Macro undefined: no refractory flags; REQ-019/020 apply every timestep.

Structure
REQ-029 Package snn_pkg holds the FSM state enum and the saturation function.
REQ-030 One sub-module snn_synapse_sum (combinational signed popcount difference, REQ-018); the potential array is a register array in the top.

Verification (INPUTS=16, NEURONS=8, POT_BITS=8)
REQ-031 After reset, threshold 3, shift 0, in_spikes 16'h000F -> out_spikes 8'hFF, out_valid at t+9, all potentials 1.
REQ-032 Upload 16 bytes 8'h00, in_spikes 16'hFFFF, threshold 3, eight timesteps -> out_spikes 0 throughout; potentials -16, -32, ..., saturating at -128.
REQ-033 Default weights, shift 1, threshold 100, in_spikes 16'h0003 repeated -> potentials 2, 3, 4, 4; no spikes.
REQ-034 out_ready low 5 cycles after out_valid -> out_valid and out_spikes held; in_ready and wgt_ready 0; in_valid pulses ignored.
REQ-035 Reset asserted in ACC cycle 3 -> next cycle outputs 0, busy 0, weights all ones, potentials 0.
REQ-036 Threshold 3, in_spikes 16'h000F for three timesteps -> with SNN_REFRACTORY_EN: FF, 00, FF; without: FF, FF, FF.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg -- shared definitions for the time-multiplexed spiking layer.
//   state_t    : controller states (IDLE, ACC, DONE)
//   sat_signed : clamps a 32-bit signed value into a signed range of 'bits' bits
// Optional feature macro used by the layer: SNN_REFRACTORY_EN.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Clamp val into [-(2^(bits-1)), 2^(bits-1)-1]; the result is still
  // 32 bits wide so callers slice off the low 'bits' bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/snn_synapse_sum.sv
// snn_synapse_sum -- combinational signed synaptic sum for one neuron.
//   spikes  [INPUTS]   : input spike vector for the current timestep
//   weights [INPUTS]   : binary weights, 1 = +1, 0 = -1
//   sum     [SUM_BITS] : popcount(spikes & weights) - popcount(spikes & ~weights)
module snn_synapse_sum #(
  parameter int INPUTS   = 16,
  parameter int SUM_BITS = $clog2(INPUTS) + 2
) (
  input  logic [INPUTS-1:0]          spikes,
  input  logic [INPUTS-1:0]          weights,
  output logic signed [SUM_BITS-1:0] sum
);

  logic [SUM_BITS-1:0] pos_cnt;
  logic [SUM_BITS-1:0] neg_cnt;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (spikes[i]) begin
        if (weights[i]) begin
          pos_cnt = pos_cnt + SUM_BITS'(1);
        end else begin
          neg_cnt = neg_cnt + SUM_BITS'(1);
        end
      end
    end
  end

  // Both counts are at most INPUTS, so the modular difference is the
  // correct two's-complement result within SUM_BITS.
  assign sum = pos_cnt - neg_cnt;

endmodule

// File: rtl/snn_tdm_layer.sv
// snn_tdm_layer -- layer of NEURONS leaky integrate-and-fire neurons with
// binary (+1/-1) weights, evaluated one neuron per clock over a single
// shared synaptic-sum unit.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   clr                          : zero all potentials (honoured in IDLE only)
//   threshold [POT_BITS], shift  : firing threshold and leak shift, captured at timestep start
//   wgt_valid/wgt_ready/wgt_data : weight byte stream, shifted in from the top
//   in_valid/in_ready/in_spikes  : starts a timestep with the given input spikes
//   out_valid/out_ready/out_spikes : timestep result, held until accepted
//   busy                         : high whenever a timestep is in progress or pending
// Optional feature: define SNN_REFRACTORY_EN to give each neuron a one-timestep
// refractory period after it spikes.
module snn_tdm_layer
  import snn_pkg::*;
#(
  parameter int INPUTS   = 16,
  parameter int NEURONS  = 8,
  parameter int POT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic [POT_BITS-1:0] threshold,
  input  logic [2:0]          shift,
  input  logic                wgt_valid,
  output logic                wgt_ready,
  input  logic [7:0]          wgt_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INPUTS-1:0]   in_spikes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NEURONS-1:0]  out_spikes,
  output logic                busy
);

  localparam int W        = INPUTS * NEURONS;
  localparam int SUM_BITS = $clog2(INPUTS) + 2;
  localparam int IDX_BITS = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NEURONS - 1);

  state_t                     state_reg;
  logic [IDX_BITS-1:0]        idx_reg;
  logic [W-1:0]               weights_reg;
  logic signed [POT_BITS-1:0] pot_reg [NEURONS];
  logic [INPUTS-1:0]          spikes_reg;
  logic [POT_BITS-1:0]        thr_reg;
  logic [2:0]                 shift_reg;
  logic [NEURONS-1:0]         out_spikes_reg;
  logic                       out_valid_reg;
  logic                       busy_reg;
`ifdef SNN_REFRACTORY_EN
  logic [NEURONS-1:0]         refr_reg;
`endif

  // Handshakes
  logic in_fire;
  logic wgt_fire;
  assign in_ready  = (state_reg == ST_IDLE) && !clr;
  assign wgt_ready = (state_reg == ST_IDLE) && !in_valid && !clr;
  assign in_fire   = in_valid && in_ready;
  assign wgt_fire  = wgt_valid && wgt_ready;

  assign out_valid  = out_valid_reg;
  assign out_spikes = out_spikes_reg;
  assign busy       = busy_reg;

  // Per-neuron weight slices, selected by the neuron index during ACC.
  logic [INPUTS-1:0] w_slice [NEURONS];
  genvar gi;
  generate
    for (gi = 0; gi < NEURONS; gi++) begin : gen_wslice
      assign w_slice[gi] = weights_reg[gi*INPUTS +: INPUTS];
    end
  endgenerate

  logic [INPUTS-1:0]          cur_w;
  logic signed [SUM_BITS-1:0] sum;
  assign cur_w = w_slice[idx_reg];

  snn_synapse_sum #(
    .INPUTS   (INPUTS),
    .SUM_BITS (SUM_BITS)
  ) u_sum (
    .spikes  (spikes_reg),
    .weights (cur_w),
    .sum     (sum)
  );

  // Neuron update for the neuron selected by idx_reg. Arithmetic is done
  // at 32 bits so the leak/sum combination cannot wrap before saturation.
  logic signed [POT_BITS-1:0] cur_pot;
  logic signed [31:0]         cur_ext;
  logic signed [31:0]         leak;
  logic signed [31:0]         sum_eff;
  logic signed [31:0]         raw;
  logic signed [31:0]         sat_val;
  logic signed [31:0]         thr_ext;
  logic signed [POT_BITS-1:0] u_next;
  logic signed [POT_BITS-1:0] u_after;
  logic                       fire;
  logic                       refractory;

  always_comb begin
    cur_pot = pot_reg[idx_reg];
    cur_ext = {{(32-POT_BITS){cur_pot[POT_BITS-1]}}, cur_pot};
    leak    = (shift_reg != 3'd0) ? (cur_ext >>> shift_reg) : 32'sd0;
`ifdef SNN_REFRACTORY_EN
    refractory = refr_reg[idx_reg];
`else
    refractory = 1'b0;
`endif
    sum_eff = refractory ? 32'sd0 : {{(32-SUM_BITS){sum[SUM_BITS-1]}}, sum};
    raw     = cur_ext - leak + sum_eff;
    sat_val = sat_signed(raw, POT_BITS);
    u_next  = sat_val[POT_BITS-1:0];
    // Threshold is unsigned, so it is zero-extended before the signed compare.
    thr_ext = {{(32-POT_BITS){1'b0}}, thr_reg};
    fire    = !refractory && (sat_val >= thr_ext);
    // When firing, u_next >= threshold >= 0, so the narrow subtraction is exact.
    u_after = fire ? (u_next - thr_reg) : u_next;
  end

  // Controller: sequencing, captured configuration and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      weights_reg   <= '1;
      spikes_reg    <= '0;
      thr_reg       <= '0;
      shift_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_fire) begin
            spikes_reg <= in_spikes;
            thr_reg    <= threshold;
            shift_reg  <= shift;
            idx_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_ACC;
          end else if (wgt_fire) begin
            weights_reg <= {wgt_data, weights_reg[W-1:8]};
          end
        end
        ST_ACC: begin
          idx_reg <= idx_reg + IDX_BITS'(1);
          if (idx_reg == LAST_IDX) begin
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Membrane potentials, result bits and (optionally) refractory flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NEURONS; k++) begin
        pot_reg[k] <= '0;
      end
      out_spikes_reg <= '0;
`ifdef SNN_REFRACTORY_EN
      refr_reg <= '0;
`endif
    end else if ((state_reg == ST_IDLE) && clr) begin
      for (int k = 0; k < NEURONS; k++) begin
        pot_reg[k] <= '0;
      end
`ifdef SNN_REFRACTORY_EN
      refr_reg <= '0;
`endif
    end else if (state_reg == ST_ACC) begin
      pot_reg[idx_reg]        <= u_after;
      out_spikes_reg[idx_reg] <= fire;
`ifdef SNN_REFRACTORY_EN
      refr_reg[idx_reg] <= fire;
`endif
    end
  end

endmodule

// File: tb/tb_snn_tdm_layer.sv
// tb_snn_tdm_layer -- self-checking bench for snn_tdm_layer (16 inputs,
// 8 neurons, 8-bit potentials). A behavioural model tracks weights,
// potentials and refractory flags with plain integer arithmetic.
module tb_snn_tdm_layer;

  localparam int NI = 16;
  localparam int NN = 8;
  localparam int PB = 8;
`ifdef SNN_REFRACTORY_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr = 1'b0;
  logic [PB-1:0] threshold = '0;
  logic [2:0]    shift = '0;
  logic          wgt_valid = 1'b0;
  logic          wgt_ready;
  logic [7:0]    wgt_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NI-1:0] in_spikes = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NN-1:0] out_spikes;
  logic          busy;

  snn_tdm_layer #(.INPUTS(NI), .NEURONS(NN), .POT_BITS(PB)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .threshold  (threshold),
    .shift      (shift),
    .wgt_valid  (wgt_valid),
    .wgt_ready  (wgt_ready),
    .wgt_data   (wgt_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_spikes  (in_spikes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_spikes (out_spikes),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state
  logic [NI*NN-1:0] weights_m;
  int               pot_m [NN];
  bit               refr_m [NN];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [NN-1:0] model_step(input logic [NI-1:0] spk, input int thr, input int sh);
    logic [NN-1:0] res;
    res = '0;
    for (int k = 0; k < NN; k++) begin
      int  s;
      int  v;
      int  leak;
      bit  rf;
      s = 0;
      for (int i = 0; i < NI; i++)
        if (spk[i]) s += weights_m[k*NI+i] ? 1 : -1;
      leak = (sh != 0) ? floor_div(pot_m[k], 1 << sh) : 0;
      rf = REFR && refr_m[k];
      v = pot_m[k] - leak + (rf ? 0 : s);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      if (!rf && v >= thr) begin
        res[k] = 1'b1;
        v -= thr;
      end
      refr_m[k] = res[k];
      pot_m[k] = v;
    end
    return res;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NN; k++) begin
      pot_m[k] = 0;
      refr_m[k] = 1'b0;
    end
  endtask

  task automatic chk_pots(input string tag);
    logic [7:0] o;
    logic [7:0] e;
    for (int k = 0; k < NN; k++) begin
      o = dut.pot_reg[k];
      e = pot_m[k][7:0];
      chk($sformatf("%s pot%0d", tag, k), o, e);
    end
  endtask

  task automatic do_reset();
    in_valid = 0; wgt_valid = 0; clr = 0; out_ready = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_clear();
    weights_m = '1;
  endtask

  task automatic upload_byte(input logic [7:0] b);
    @(negedge clk);
    chk("wgt_ready idle", wgt_ready, 1);
    wgt_valid = 1; wgt_data = b;
    @(posedge clk); #1;
    wgt_valid = 0;
    weights_m = {b, weights_m[NI*NN-1:8]};
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1; in_valid = 1; wgt_valid = 1;
    #1;
    chk("clr in_ready", in_ready, 0);
    chk("clr wgt_ready", wgt_ready, 0);
    @(posedge clk); #1;
    clr = 0; in_valid = 0; wgt_valid = 0;
    model_clear();
    @(negedge clk);
    chk_pots("after clr");
    chk("clr weights", dut.weights_reg, weights_m);
    $display("clr: potentials zeroed");
  endtask

  task automatic run_step(input logic [NI-1:0] spk, input logic [7:0] thr, input logic [2:0] sh,
                          input int hold, input string tag, output logic [NN-1:0] obs);
    int cyc;
    logic [NN-1:0] exp_spk;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1; in_spikes = spk; threshold = thr; shift = sh;
    @(posedge clk); #1;
    in_valid = 0; in_spikes = $urandom; threshold = $urandom; shift = $urandom;
    exp_spk = model_step(spk, thr, sh);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, " busy"}, busy, 1);
      if (!out_valid) begin
        clr = $urandom; wgt_valid = $urandom; wgt_data = $urandom; in_valid = $urandom;
      end
    end while (!out_valid && cyc < 40);
    clr = 0; wgt_valid = 0; in_valid = 0;
    chk({tag, " latency"}, cyc, NN + 1);
    chk({tag, " out_spikes"}, out_spikes, exp_spk);
    obs = out_spikes;
    chk_pots(tag);
    for (int h = 0; h < hold; h++) begin
      in_valid = $urandom; wgt_valid = h[0]; wgt_data = $urandom;
      @(negedge clk);
      chk({tag, " hold out_valid"}, out_valid, 1);
      chk({tag, " hold out_spikes"}, out_spikes, exp_spk);
      chk({tag, " hold in_ready"}, in_ready, 0);
      chk({tag, " hold wgt_ready"}, wgt_ready, 0);
    end
    in_valid = 0; wgt_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk({tag, " out_valid drop"}, out_valid, 0);
    chk({tag, " busy drop"}, busy, 0);
    chk({tag, " weights"}, dut.weights_reg, weights_m);
    $display("%s: in=%h thr=%0d sh=%0d -> spikes %h (expect %h) latency %0d",
             tag, spk, thr, sh, obs, exp_spk, cyc);
  endtask

  initial begin
    logic [NN-1:0] obs;
    logic [NN-1:0] exp036 [3];
    logic [7:0]    exp033 [4];
    logic [7:0]    e8;
    logic [7:0]    o8;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_spikes", out_spikes, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset wgt_ready", wgt_ready, 1);
    chk("reset weights", dut.weights_reg, weights_m);
    chk_pots("reset");
    $display("reset: state checked");

    // First timestep, then two more for the refractory behaviour
    exp036[0] = 8'hFF; exp036[1] = REFR ? 8'h00 : 8'hFF; exp036[2] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      run_step(16'h000F, 8'd3, 3'd0, 0, $sformatf("basic%0d", n), obs);
      chk($sformatf("basic%0d pattern", n), obs, exp036[n]);
      if (n == 0)
        for (int k = 0; k < NN; k++) begin
          o8 = dut.pot_reg[k];
          chk($sformatf("basic0 pot%0d is 1", k), o8, 8'd1);
        end
    end

    do_clr();

    // Leak with shift 1
    do_reset();
    exp033[0] = 8'd2; exp033[1] = 8'd3; exp033[2] = 8'd4; exp033[3] = 8'd4;
    for (int n = 0; n < 4; n++) begin
      run_step(16'h0003, 8'd100, 3'd1, 0, $sformatf("leak%0d", n), obs);
      chk($sformatf("leak%0d no spikes", n), obs, 0);
      o8 = dut.pot_reg[3];
      chk($sformatf("leak%0d pot3", n), o8, exp033[n]);
    end

    // Backpressure for five cycles
    run_step(16'h0F0F, 8'd2, 3'd0, 5, "hold5", obs);

    // All-negative weights saturate downwards
    do_reset();
    for (int b = 0; b < NI * NN / 8; b++) upload_byte(8'h00);
    for (int n = 1; n <= 8; n++) begin
      run_step(16'hFFFF, 8'd3, 3'd0, 0, $sformatf("neg%0d", n), obs);
      chk($sformatf("neg%0d no spikes", n), obs, 0);
      e8 = 8'((-16 * n < -128) ? -128 : -16 * n);
      o8 = dut.pot_reg[7];
      chk($sformatf("neg%0d pot7", n), o8, e8);
    end

    // Reset during ACC aborts the timestep
    for (int b = 0; b < NI * NN / 8; b++) upload_byte(8'($urandom));
    @(negedge clk);
    in_valid = 1; in_spikes = 16'hFFFF; threshold = 8'd1; shift = 3'd0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort out_spikes", out_spikes, 0);
    chk("abort weights", dut.weights_reg, {(NI*NN){1'b1}});
    reset = 0;
    model_clear();
    weights_m = '1;
    chk_pots("abort");
    $display("abort: reset in ACC cycle 3 checked");

    // Randomised timesteps with random weights and occasional clears
    for (int b = 0; b < NI * NN / 8; b++) upload_byte(8'($urandom));
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0) do_clr();
      run_step(16'($urandom), 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
               $urandom_range(0, 3), $sformatf("rand%0d", n), obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
